adc_xy_plot: RTL
================

# adc_xy_plot

Point plotter directly downstream of the ADC XY capture stage. It consumes scaled (x, y, r, g, b) samples over a valid/ready handshake, discards off-screen, blank and repeated points, and issues single-pixel framebuffer writes over a second valid/ready port. On reset or on request it first sweeps the whole framebuffer to black.

## Interface
Parameters:
- DATA_WIDTH, 10, width of incoming x/y coordinates
- H_VISIBLE, 640, framebuffer width in pixels
- V_VISIBLE, 480, framebuffer height in pixels
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2**ADDR_WIDTH >= H_VISIBLE*V_VISIBLE
- PIXEL_BITS, 12, framebuffer pixel width (RGB 4:4:4); must be a multiple of 3

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- clear  in  1  single-cycle request to black out the framebuffer
- s_valid  in  1  input point valid (from adc_valid)
- s_ready  out  1  input point accepted when s_valid && s_ready
- s_x, s_y  in  DATA_WIDTH  point coordinates
- s_red, s_grn, s_blu  in  1  beam colour bits
- m_valid  out  1  framebuffer write valid
- m_ready  in  1  framebuffer write accepted when m_valid && m_ready
- m_addr  out  ADDR_WIDTH  pixel address
- m_data  out  PIXEL_BITS  pixel value
- busy  out  1  clear sweep in progress
- drop_cnt  out  16  saturating count of off-screen points

## Operation
States are CLEAR and RUN.

Reset:
- state=CLEAR, sweep counter=0.
- m_valid=0, m_addr=0, m_data=0.
- busy=1, drop_cnt=0.
- last-write tracker invalid.

CLEAR:
- s_ready=0.
- The output register presents addr=sweep counter, data=0.
- The counter advances on each m handshake.
- The handshake at addr H_VISIBLE*V_VISIBLE-1 moves the block to RUN and invalidates the last-write tracker.
- clear while in CLEAR is ignored.

RUN:
- s_ready = !clear_pending && (!m_valid || m_ready). This is the only combinational input-to-output path.
- Every accepted point is classified in priority order:
  - x >= H_VISIBLE or y >= V_VISIBLE: discard, drop_cnt++ (saturates at 16'hFFFF).
  - r=g=b=0: discard silently.
  - addr and colour equal to the last-written pixel: discard silently.
  - Otherwise load the output register: m_addr = y*H_VISIBLE + x, truncated to ADDR_WIDTH. m_data is each colour bit replicated PIXEL_BITS/3 times, ordered {R,G,B}. Update the last-write tracker.

clear handling:
- clear in RUN sets clear_pending, which deasserts s_ready.
- The transition to CLEAR (counter=0) occurs in the cycle where the output register is empty or its handshake completes.
- The pending write is never dropped.
- clear coincident with an accepted point: the point is discarded.

## Timing
- Point accepted in cycle N: m_valid=1 with its addr/data in cycle N+1.
- Throughput is one point per cycle while m_ready=1.
- Once m_valid=1, m_addr and m_data stay stable until the handshake.
- The first clear write (addr 0) is presented in the first cycle after rst deasserts.
- A full sweep takes H_VISIBLE*V_VISIBLE cycles with m_ready held high.
- busy falls in the cycle after the final sweep handshake; s_ready may rise in that same cycle.
- rst mid-sweep or mid-RUN:
  - the sweep restarts from addr 0 on release;
  - the in-flight write is abandoned;
  - drop_cnt is zeroed.
- drop_cnt is not affected by clear.

## Structure
- Package adc_xy_plot_pkg holds:
  - state_t {CLEAR, RUN};
  - a colour-expand function (1-bit channel to PIXEL_BITS/3 bits);
  - a localparam helper for the H*V pixel count.
- No sub-module is needed:
  - one output register stage;
  - a constant-multiply address computation, registered into the output stage;
  - the sweep counter and the tracker.

## Test plan
Benches use H_VISIBLE=8, V_VISIBLE=4 unless noted.
- Reset and sweep: release rst, hold m_ready=1. Expect 32 writes, addr 0..31, data 0, busy=1 throughout, then busy=0 and s_ready=1 one cycle later.
- Basic plot at default size: red (100,200) gives m_addr=128100, m_data=12'hF00. Green (300,400), presented next cycle, gives m_addr=256300, m_data=12'h0F0.
- Filtering:
  - (8,0) red and (0,4) green: no writes, drop_cnt=2.
  - (3,1) black: no write, drop_cnt unchanged.
  - (3,1) blue twice: one write, addr 11, data 12'h00F.
- Backpressure: hold m_ready=0 with a write pending. s_ready=0, and m_addr/m_data hold for 5 cycles. Raise m_ready: handshake, then the next point is accepted the same cycle.
- clear mid-RUN with a write pending and m_ready=0: the pending write completes first, then the sweep runs addr 0..31. The next (3,1) blue point is written even though it repeats the last pre-clear write.
- rst mid-sweep at addr 17: after release the sweep restarts at addr 0, and drop_cnt=0.

Source files
------------

// File: rtl/adc_xy_plot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_xy_plot_pkg
// Description : Shared types and helpers for the ADC XY point plotter.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_xy_plot_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Number of pixels in an h x v framebuffer.
    function automatic int pixel_count(input int h, input int v);
        return h * v;
    endfunction

    // Replicate one beam colour bit across the low 'width' bits of a channel.
    function automatic logic [31:0] colour_expand(input logic bit_in, input int width);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                v[i] = bit_in;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_xy_plot_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_xy_plot_if
// Description : Point input and pixel-write output handshakes of the plotter.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_xy_plot_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 19,
    parameter int PIXEL_BITS = 12
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_x;
    logic [DATA_WIDTH-1:0] s_y;
    logic                  s_red;
    logic                  s_grn;
    logic                  s_blu;
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [PIXEL_BITS-1:0] m_data;

    // The plotter: consumes points, produces framebuffer writes.
    modport slave (
        input  s_valid, s_x, s_y, s_red, s_grn, s_blu, m_ready,
        output s_ready, m_valid, m_addr, m_data
    );

    // The surrounding system: point source and framebuffer sink.
    modport master (
        output s_valid, s_x, s_y, s_red, s_grn, s_blu, m_ready,
        input  s_ready, m_valid, m_addr, m_data
    );
endinterface
`default_nettype wire

// File: rtl/adc_xy_plot.sv
`default_nettype none
// ============================================================================
// Module      : adc_xy_plot
// Description : Filters scaled XY points and issues single-pixel framebuffer
//               writes; sweeps the framebuffer to black on reset or clear.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_xy_plot #(
    parameter int DATA_WIDTH = 10,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int PIXEL_BITS = 12
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    adc_xy_plot_if.slave     bus,
    output logic             busy,
    output logic [15:0]      drop_cnt
);
    import adc_xy_plot_pkg::*;

    localparam int                    c_npix      = pixel_count(H_VISIBLE, V_VISIBLE);
    localparam int                    c_ch        = PIXEL_BITS / 3;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_npix - 1);
    localparam logic [31:0]           c_h_vis     = 32'(H_VISIBLE);
    localparam logic [31:0]           c_v_vis     = 32'(V_VISIBLE);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sweep;
    logic                  r_m_valid;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [PIXEL_BITS-1:0] r_m_data;
    logic                  r_clear_pending;
    logic [15:0]           r_drop_cnt;
    logic                  r_last_valid;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [PIXEL_BITS-1:0] r_last_data;

    logic                  w_out_free;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_offscreen;
    logic                  w_black;
    logic                  w_repeat;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [PIXEL_BITS-1:0] w_data;

    assign w_out_free  = !r_m_valid || bus.m_ready;
    assign w_s_ready   = (r_state == RUN) && !r_clear_pending && w_out_free;
    assign w_accept    = bus.s_valid && w_s_ready;
    assign w_offscreen = (32'(bus.s_x) >= c_h_vis) || (32'(bus.s_y) >= c_v_vis);
    assign w_black     = !(bus.s_red || bus.s_grn || bus.s_blu);
    assign w_addr      = ADDR_WIDTH'(32'(bus.s_y) * c_h_vis + 32'(bus.s_x));
    assign w_data      = {c_ch'(colour_expand(bus.s_red, c_ch)),
                          c_ch'(colour_expand(bus.s_grn, c_ch)),
                          c_ch'(colour_expand(bus.s_blu, c_ch))};
    assign w_repeat    = r_last_valid && (w_addr == r_last_addr) && (w_data == r_last_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= CLEAR;
            r_sweep         <= '0;
            r_m_valid       <= 1'b0;
            r_m_addr        <= '0;
            r_m_data        <= '0;
            r_clear_pending <= 1'b0;
            r_drop_cnt      <= '0;
            r_last_valid    <= 1'b0;
            r_last_addr     <= '0;
            r_last_data     <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_addr  <= r_sweep;
                        r_m_data  <= '0;
                    end else if (bus.m_ready) begin
                        if (r_sweep == c_last_addr) begin
                            r_state      <= RUN;
                            r_m_valid    <= 1'b0;
                            r_last_valid <= 1'b0;
                        end else begin
                            r_sweep  <= r_sweep + 1'b1;
                            r_m_addr <= r_sweep + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_m_valid && bus.m_ready) begin
                        r_m_valid <= 1'b0;
                    end
                    // A pending clear waits for the output register to drain,
                    // then starts the sweep with its first write already loaded.
                    if (r_clear_pending && w_out_free) begin
                        r_state         <= CLEAR;
                        r_clear_pending <= 1'b0;
                        r_sweep         <= '0;
                        r_m_valid       <= 1'b1;
                        r_m_addr        <= '0;
                        r_m_data        <= '0;
                    end else begin
                        if (clear) begin
                            r_clear_pending <= 1'b1;
                        end
                        if (w_accept && !clear) begin
                            if (w_offscreen) begin
                                if (r_drop_cnt != 16'hFFFF) begin
                                    r_drop_cnt <= r_drop_cnt + 16'd1;
                                end
                            end else if (!w_black && !w_repeat) begin
                                r_m_valid    <= 1'b1;
                                r_m_addr     <= w_addr;
                                r_m_data     <= w_data;
                                r_last_valid <= 1'b1;
                                r_last_addr  <= w_addr;
                                r_last_data  <= w_data;
                            end
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_data  = r_m_data;
    assign busy        = (r_state == CLEAR);
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire
